// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flag unit: ARMv4 condition codes,
// NZCV bit positions and FLAG_WRITE bit positions.
package cond_pkg;

    // ARMv4 condition field encodings, instruction bits [31:28].
    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
        MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
        HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
    } cond_e;

    // Bit positions inside NZCV_Q / ALU_FLAGS.
    localparam int N_IDX = 0;
    localparam int Z_IDX = 1;
    localparam int C_IDX = 2;
    localparam int V_IDX = 3;

    // Bit positions inside FLAG_WRITE.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Decoder/ALU side bundle of the condition/flag unit. The master drives the
// instruction and ungated enables; the slave (the unit) returns gated enables,
// the condition result, the flags and the performance counters.
interface cond_flag_unit_if #(
    parameter int CNT_BITS = 32
);
    logic                VALID_IN;
    logic                STALL;
    logic                FLUSH;
    logic [3:0]          COND;
    logic [1:0]          FLAG_WRITE;
    logic [3:0]          ALU_FLAGS;
    logic                REG_WRITE_IN;
    logic                MEM_WRITE_IN;
    logic                PC_SRC_IN;
    logic                REG_WRITE;
    logic                MEM_WRITE;
    logic                PC_SRC;
    logic                COND_EX;
    logic [3:0]          NZCV_Q;
    logic [CNT_BITS-1:0] EXEC_CNT;
    logic [CNT_BITS-1:0] ANNUL_CNT;

    modport master (
        output VALID_IN, STALL, FLUSH, COND, FLAG_WRITE, ALU_FLAGS,
               REG_WRITE_IN, MEM_WRITE_IN, PC_SRC_IN,
        input  REG_WRITE, MEM_WRITE, PC_SRC, COND_EX, NZCV_Q, EXEC_CNT, ANNUL_CNT
    );

    modport slave (
        input  VALID_IN, STALL, FLUSH, COND, FLAG_WRITE, ALU_FLAGS,
               REG_WRITE_IN, MEM_WRITE_IN, PC_SRC_IN,
        output REG_WRITE, MEM_WRITE, PC_SRC, COND_EX, NZCV_Q, EXEC_CNT, ANNUL_CNT
    );
endinterface

// File: rtl/cond_check.sv
// Pure combinational ARMv4 condition decoder: (COND, NZCV) -> pass.
// Kept standalone so a predicated-branch unit can reuse it.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);
    logic n, z, c, v;

    assign n = nzcv_i[N_IDX];
    assign z = nzcv_i[Z_IDX];
    assign c = nzcv_i[C_IDX];
    assign v = nzcv_i[V_IDX];

    // Decode the condition field against the current flags.
    // NOTE: every variable written in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            EQ: pass_o = z;
            NE: pass_o = !z;
            CS: pass_o = c;
            CC: pass_o = !c;
            MI: pass_o = n;
            PL: pass_o = !n;
            VS: pass_o = v;
            VC: pass_o = !v;
            HI: pass_o = c && !z;
            LS: pass_o = !c || z;
            GE: pass_o = (n == v);
            LT: pass_o = (n != v);
            GT: pass_o = !z && (n == v);
            LE: pass_o = z || (n != v);
            AL: pass_o = 1'b1;
            NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register, condition gating of the write/redirect enables
// and executed/annulled instruction counters.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int CNT_BITS = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    cond_flag_unit_if.slave bus
);
    logic [3:0]          nzcv_q,  nzcv_d;
    logic [CNT_BITS-1:0] exec_q,  exec_d;
    logic [CNT_BITS-1:0] annul_q, annul_d;
    logic                cond_ex;
    logic                act;

    // Decode is on the registered flags only; ALU_FLAGS never feed it.
    cond_check u_cond_check (
        .cond_i (bus.COND),
        .nzcv_i (nzcv_q),
        .pass_o (cond_ex)
    );

    // An instruction really issues only when present, not cancelled, not held and not in reset.
    assign act = bus.VALID_IN && !bus.FLUSH && !bus.STALL && !RESET;

    assign bus.COND_EX   = cond_ex;
    assign bus.REG_WRITE = bus.REG_WRITE_IN && cond_ex && act;
    assign bus.MEM_WRITE = bus.MEM_WRITE_IN && cond_ex && act;
    assign bus.PC_SRC    = bus.PC_SRC_IN    && cond_ex && act;
    assign bus.NZCV_Q    = nzcv_q;
    assign bus.EXEC_CNT  = exec_q;
    assign bus.ANNUL_CNT = annul_q;

    // Next flags and counters: only an issuing instruction changes anything.
    always_comb begin
        nzcv_d  = nzcv_q;
        exec_d  = exec_q;
        annul_d = annul_q;
        if (act) begin
            if (cond_ex) begin
                exec_d = exec_q + 1'b1;
                if (bus.FLAG_WRITE[FW_NZ]) begin
                    nzcv_d[N_IDX] = bus.ALU_FLAGS[N_IDX];
                    nzcv_d[Z_IDX] = bus.ALU_FLAGS[Z_IDX];
                end
                if (bus.FLAG_WRITE[FW_CV]) begin
                    nzcv_d[C_IDX] = bus.ALU_FLAGS[C_IDX];
                    nzcv_d[V_IDX] = bus.ALU_FLAGS[V_IDX];
                end
            end else begin
                annul_d = annul_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            nzcv_q  <= 4'b0000;
            exec_q  <= '0;
            annul_q <= '0;
        end else begin
            nzcv_q  <= nzcv_d;
            exec_q  <= exec_d;
            annul_q <= annul_d;
        end
    end
endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model of the flag/condition rules.
module tb_cond_flag_unit;
    import cond_pkg::*;

    localparam int CB = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model state.
    bit       model_valid = 1'b0;
    bit [3:0] m_nzcv;
    int       m_exec;
    int       m_annul;

    cond_flag_unit_if #(.CNT_BITS(CB)) bus ();

    cond_flag_unit #(.CNT_BITS(CB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM-style pairing: odd codes are the inverse of the even code below them.
    function automatic bit model_pass(input int cond, input bit [3:0] f);
        bit n, z, c, v, base;
        n = f[0]; z = f[1]; c = f[2]; v = f[3];
        case (cond / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ bit'(cond % 2);
    endfunction

    function automatic bit model_act();
        return bus.VALID_IN && !bus.FLUSH && !bus.STALL && !RESET;
    endfunction

    // Model update on the active edge, from the inputs present at that edge.
    always @(posedge CLK) begin
        if (RESET) begin
            m_nzcv      = 4'b0000;
            m_exec      = 0;
            m_annul     = 0;
            model_valid = 1'b1;
        end else if (model_valid && model_act()) begin
            if (model_pass(int'(bus.COND), m_nzcv)) begin
                m_exec = (m_exec + 1) % (1 << CB);
                if (bus.FLAG_WRITE[1]) m_nzcv[1:0] = bus.ALU_FLAGS[1:0];
                if (bus.FLAG_WRITE[0]) m_nzcv[3:2] = bus.ALU_FLAGS[3:2];
            end else begin
                m_annul = (m_annul + 1) % (1 << CB);
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge CLK) begin
        if (model_valid) begin
            bit p, a;
            p = model_pass(int'(bus.COND), m_nzcv);
            a = model_act();
            check("cmp_cond_ex",   32'(bus.COND_EX),   32'(p));
            check("cmp_reg_write", 32'(bus.REG_WRITE), 32'(bus.REG_WRITE_IN && p && a));
            check("cmp_mem_write", 32'(bus.MEM_WRITE), 32'(bus.MEM_WRITE_IN && p && a));
            check("cmp_pc_src",    32'(bus.PC_SRC),    32'(bus.PC_SRC_IN && p && a));
            check("cmp_nzcv",      32'(bus.NZCV_Q),    32'(m_nzcv));
            check("cmp_exec_cnt",  32'(bus.EXEC_CNT),  32'(m_exec));
            check("cmp_annul_cnt", 32'(bus.ANNUL_CNT), 32'(m_annul));
        end
    end

    task automatic drive(input bit v, input bit st, input bit fl, input logic [3:0] cond,
                         input logic [1:0] fw, input logic [3:0] alu,
                         input bit rw, input bit mw, input bit pc);
        bus.VALID_IN     = v;
        bus.STALL        = st;
        bus.FLUSH        = fl;
        bus.COND         = cond;
        bus.FLAG_WRITE   = fw;
        bus.ALU_FLAGS    = alu;
        bus.REG_WRITE_IN = rw;
        bus.MEM_WRITE_IN = mw;
        bus.PC_SRC_IN    = pc;
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // 1. Reset held for two edges with a full-enable AL instruction present.
        RESET = 1'b1;
        drive(1, 0, 0, AL, 2'b11, 4'hF, 1, 1, 1);
        @(negedge CLK);
        check("rst_reg_write_pre", 32'(bus.REG_WRITE), 0);
        next();
        @(negedge CLK);
        check("rst_reg_write", 32'(bus.REG_WRITE), 0);
        check("rst_mem_write", 32'(bus.MEM_WRITE), 0);
        check("rst_pc_src",    32'(bus.PC_SRC),    0);
        check("rst_nzcv",      32'(bus.NZCV_Q),    0);
        check("rst_exec",      32'(bus.EXEC_CNT),  0);
        check("rst_annul",     32'(bus.ANNUL_CNT), 0);
        next();
        RESET = 1'b0;

        // 2. Flag latency: Z written by AL, seen by the following instruction.
        drive(1, 0, 0, AL, 2'b11, 4'b0010, 1, 0, 0);
        @(negedge CLK);
        check("lat_al_reg_write", 32'(bus.REG_WRITE), 1);
        check("lat_nzcv_before",  32'(bus.NZCV_Q), 0);
        next();
        drive(1, 0, 0, EQ, 2'b00, 4'b0000, 1, 0, 0);
        @(negedge CLK);
        check("lat_nzcv_after", 32'(bus.NZCV_Q), 4'b0010);
        check("lat_eq_reg_write", 32'(bus.REG_WRITE), 1);
        bus.COND = NE;
        #1;
        check("lat_ne_reg_write", 32'(bus.REG_WRITE), 0);
        next();
        @(negedge CLK);
        check("lat_annul", 32'(bus.ANNUL_CNT), 1);
        check("lat_exec",  32'(bus.EXEC_CNT),  1);

        // 3. Partial write: only N,Z updated.
        drive(1, 0, 0, AL, 2'b11, 4'b1111, 0, 0, 0);
        next();
        drive(1, 0, 0, AL, 2'b10, 4'b0000, 0, 0, 0);
        next();
        @(negedge CLK);
        check("partial_nzcv", 32'(bus.NZCV_Q), 4'b1100);

        // 4. Signed compares, N=1 V=1 then N=1 V=0.
        drive(1, 0, 0, AL, 2'b11, 4'b1001, 0, 0, 0);
        next();
        bus.VALID_IN = 1'b0;
        bus.COND = GE; #1 check("n1v1_ge", 32'(bus.COND_EX), 1);
        bus.COND = LT; #1 check("n1v1_lt", 32'(bus.COND_EX), 0);
        bus.COND = GT; #1 check("n1v1_gt", 32'(bus.COND_EX), 1);
        bus.COND = LE; #1 check("n1v1_le", 32'(bus.COND_EX), 0);
        drive(1, 0, 0, AL, 2'b11, 4'b0001, 0, 0, 0);
        next();
        bus.VALID_IN = 1'b0;
        bus.COND = GE; #1 check("n1v0_ge", 32'(bus.COND_EX), 0);
        bus.COND = LT; #1 check("n1v0_lt", 32'(bus.COND_EX), 1);
        bus.COND = GT; #1 check("n1v0_gt", 32'(bus.COND_EX), 0);
        bus.COND = LE; #1 check("n1v0_le", 32'(bus.COND_EX), 1);

        // 5. Failed condition with S set writes no flags; NV always annuls.
        drive(1, 0, 0, AL, 2'b11, 4'b0000, 0, 0, 0);
        next();
        drive(1, 0, 0, EQ, 2'b11, 4'b1111, 1, 1, 1);
        @(negedge CLK);
        check("fail_reg_write", 32'(bus.REG_WRITE), 0);
        check("fail_mem_write", 32'(bus.MEM_WRITE), 0);
        check("fail_pc_src",    32'(bus.PC_SRC),    0);
        next();
        @(negedge CLK);
        check("fail_nzcv",  32'(bus.NZCV_Q), 0);
        check("fail_annul", 32'(bus.ANNUL_CNT), 2);
        drive(1, 0, 0, NV, 2'b11, 4'b1111, 1, 1, 1);
        next();
        @(negedge CLK);
        check("nv_annul", 32'(bus.ANNUL_CNT), 3);
        check("nv_exec",  32'(bus.EXEC_CNT),  6);

        // 6. Stall for three cycles, then issue once; flush and flush+stall.
        drive(1, 1, 0, AL, 2'b11, 4'b1111, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("stall_reg_write", 32'(bus.REG_WRITE), 0);
            next();
        end
        @(negedge CLK);
        check("stall_nzcv", 32'(bus.NZCV_Q), 0);
        check("stall_exec", 32'(bus.EXEC_CNT), 6);
        bus.STALL = 1'b0;
        next();
        @(negedge CLK);
        check("release_exec", 32'(bus.EXEC_CNT), 7);
        check("release_nzcv", 32'(bus.NZCV_Q), 4'b1111);
        drive(1, 0, 1, AL, 2'b11, 4'b0000, 1, 1, 1);
        @(negedge CLK);
        check("flush_pc_src", 32'(bus.PC_SRC), 0);
        next();
        bus.STALL = 1'b1;
        @(negedge CLK);
        check("flush_stall_reg_write", 32'(bus.REG_WRITE), 0);
        next();
        @(negedge CLK);
        check("flush_exec", 32'(bus.EXEC_CNT), 7);
        check("flush_nzcv", 32'(bus.NZCV_Q), 4'b1111);

        // Counter wrap: 16 executed then 16 annulled ops after a fresh reset.
        RESET = 1'b1;
        next();
        RESET = 1'b0;
        drive(1, 0, 0, AL, 2'b00, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 16; i++) next();
        @(negedge CLK);
        check("wrap_exec", 32'(bus.EXEC_CNT), 0);
        bus.COND = NV;
        for (int i = 0; i < 15; i++) next();
        @(negedge CLK);
        check("annul_15", 32'(bus.ANNUL_CNT), 15);
        next();
        @(negedge CLK);
        check("wrap_annul", 32'(bus.ANNUL_CNT), 0);

        // Randomized traffic checked by the per-cycle compare process.
        for (int i = 0; i < 3000; i++) begin
            RESET = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            next();
        end
        RESET = 1'b0;
        bus.VALID_IN = 1'b0;
        @(negedge CLK);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
